// File: rtl/pipe_cu.sv
// pipe_cu: pipelined RV32I control unit (D-stage decode, D/E-E/M-M/W control bundle,
// branch resolution, forwarding, load-use stall FSM). Optional trap: PIPE_CU_ILLEGAL_TRAP_EN.
module pipe_cu #(
  parameter int LOAD_LATENCY = 1,
  parameter int ALUCTRL_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_d,
  input  logic                 zero_e,
  input  logic                 lt_e,
  input  logic                 ltu_e,
  output logic [2:0]           immsrc_d,
  output logic                 alusrca_e,
  output logic                 alusrc_e,
  output logic [ALUCTRL_W-1:0] aluctrl_e,
  output logic [4:0]           rs1_e,
  output logic [4:0]           rs2_e,
  output logic [4:0]           rd_e,
  output logic [1:0]           fwd_a_e,
  output logic [1:0]           fwd_b_e,
  output logic                 pcsrc_e,
  output logic                 jalr_e,
  output logic                 memwrite_m,
  output logic                 regwrite_m,
  output logic [4:0]           rd_m,
  output logic                 regwrite_w,
  output logic [4:0]           rd_w,
  output logic [1:0]           resultsrc_w,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 illegal_d
);

  localparam int CNT_W = $clog2(LOAD_LATENCY + 1);

  logic [6:0] op_d;
  logic [2:0] f3_d;
  logic [4:0] rs1_d, rs2_d;
  logic       rw_d, mw_d, br_d, jp_d, jr_d, asa_d, asb_d;
  logic [1:0] rsrc_d;
  logic [3:0] ac_d;
  logic       unused_bits;

  assign op_d  = instr_d[6:0];
  assign f3_d  = instr_d[14:12];
  assign rs1_d = instr_d[19:15];
  assign rs2_d = instr_d[24:20];
  assign unused_bits = ^{instr_d[31], instr_d[29:25]};

  always_comb begin
    rw_d = 1'b0; mw_d = 1'b0; br_d = 1'b0; jp_d = 1'b0; jr_d = 1'b0;
    asa_d = 1'b0; asb_d = 1'b0; rsrc_d = 2'b00; ac_d = 4'b0000; immsrc_d = 3'b000;
    case (op_d)
      7'b0110011: begin rw_d = 1'b1; ac_d = {instr_d[30], f3_d}; end
      7'b0010011: begin
        rw_d = 1'b1; asb_d = 1'b1;
        ac_d = {(f3_d == 3'b101) & instr_d[30], f3_d};
      end
      7'b0000011: begin rw_d = 1'b1; asb_d = 1'b1; rsrc_d = 2'b01; end
      7'b0100011: begin mw_d = 1'b1; asb_d = 1'b1; immsrc_d = 3'b001; end
      7'b1100011: begin br_d = 1'b1; ac_d = 4'b1000; immsrc_d = 3'b010; end
      7'b1101111: begin
        rw_d = 1'b1; jp_d = 1'b1; asa_d = 1'b1; asb_d = 1'b1;
        rsrc_d = 2'b10; immsrc_d = 3'b100;
      end
      7'b1100111: begin rw_d = 1'b1; jp_d = 1'b1; jr_d = 1'b1; asb_d = 1'b1; rsrc_d = 2'b10; end
      7'b0110111: begin rw_d = 1'b1; rsrc_d = 2'b11; immsrc_d = 3'b011; end
      7'b0010111: begin rw_d = 1'b1; asa_d = 1'b1; asb_d = 1'b1; immsrc_d = 3'b011; end
      default: ;
    endcase
  end

  // E-stage bundle; instructions that never write carry rd=0 so they cannot forward or stall
  logic       rw_e, mw_e, br_e, jp_e;
  logic [1:0] rsrc_e, rsrc_m;
  logic [2:0] f3_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_e <= 1'b0; mw_e <= 1'b0; br_e <= 1'b0; jp_e <= 1'b0; jalr_e <= 1'b0;
      alusrca_e <= 1'b0; alusrc_e <= 1'b0; aluctrl_e <= '0; rsrc_e <= '0; f3_e <= '0;
      rs1_e <= '0; rs2_e <= '0; rd_e <= '0;
    end else if (flush_e) begin
      rw_e <= 1'b0; mw_e <= 1'b0; br_e <= 1'b0; jp_e <= 1'b0; jalr_e <= 1'b0;
      alusrca_e <= 1'b0; alusrc_e <= 1'b0; aluctrl_e <= '0; rsrc_e <= '0; f3_e <= '0;
      rs1_e <= '0; rs2_e <= '0; rd_e <= '0;
    end else begin
      rw_e <= rw_d; mw_e <= mw_d; br_e <= br_d; jp_e <= jp_d; jalr_e <= jr_d;
      alusrca_e <= asa_d; alusrc_e <= asb_d; aluctrl_e <= ALUCTRL_W'(ac_d);
      rsrc_e <= rsrc_d; f3_e <= f3_d;
      rs1_e <= rs1_d; rs2_e <= rs2_d; rd_e <= rw_d ? instr_d[11:7] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_m <= 1'b0; memwrite_m <= 1'b0; rd_m <= '0; rsrc_m <= '0;
      regwrite_w <= 1'b0; rd_w <= '0; resultsrc_w <= '0;
    end else begin
      regwrite_m <= rw_e; memwrite_m <= mw_e; rd_m <= rd_e; rsrc_m <= rsrc_e;
      regwrite_w <= regwrite_m; rd_w <= rd_m; resultsrc_w <= rsrc_m;
    end
  end

  logic cond_e, pcsrc_raw;
  always_comb begin
    case (f3_e)
      3'b000:  cond_e = zero_e;
      3'b001:  cond_e = ~zero_e;
      3'b100:  cond_e = lt_e;
      3'b101:  cond_e = ~lt_e;
      3'b110:  cond_e = ltu_e;
      3'b111:  cond_e = ~ltu_e;
      default: cond_e = 1'b0;
    endcase
  end
  assign pcsrc_raw = jp_e | (br_e & cond_e);

`ifdef PIPE_CU_ILLEGAL_TRAP_EN
  logic unknown_d, trap_q;
  assign unknown_d = !(op_d inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111});
  assign pcsrc_e   = pcsrc_raw & ~trap_q;
  assign illegal_d = unknown_d & ~pcsrc_e;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         trap_q <= 1'b0;
    else if (illegal_d) trap_q <= 1'b1;
  end
`else
  assign pcsrc_e   = pcsrc_raw;
  assign illegal_d = 1'b0;
`endif

  assign fwd_a_e = (regwrite_m && rd_m != '0 && rd_m == rs1_e) ? 2'b10 :
                   (regwrite_w && rd_w != '0 && rd_w == rs1_e) ? 2'b01 : 2'b00;
  assign fwd_b_e = (regwrite_m && rd_m != '0 && rd_m == rs2_e) ? 2'b10 :
                   (regwrite_w && rd_w != '0 && rd_w == rs2_e) ? 2'b01 : 2'b00;

  logic uses_rs2_d, ld_hit;
  assign uses_rs2_d = op_d inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign ld_hit = (rsrc_e == 2'b01) && (rd_e != '0) &&
                  ((rd_e == rs1_d) || (uses_rs2_d && rd_e == rs2_d));

  typedef enum logic {IDLE, STALL} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             holding, stall;

  // The first bubble comes from the hazard itself; STALL with cnt==0 acts like IDLE
  assign holding = (state == STALL) && (cnt != '0);
  assign stall   = ~pcsrc_e & (holding | ld_hit);
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_d = pcsrc_e;
  assign flush_e = pcsrc_e | stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; cnt <= '0;
    end else if (pcsrc_e) begin
      state <= IDLE; cnt <= '0;
    end else if (holding) begin
      cnt <= cnt - CNT_W'(1);
    end else if (ld_hit) begin
      state <= STALL; cnt <= CNT_W'(LOAD_LATENCY - 1);
    end else begin
      state <= IDLE; cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_cu.sv
// Self-checking bench for pipe_cu: two instances (LOAD_LATENCY 1 and 3) share the
// instruction stream and are compared every cycle against a stage-queue reference model.
module tb_pipe_cu;

  localparam int LL0 = 1;
  localparam int LL1 = 3;
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = NOP;
  logic        zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;

  logic [2:0] immsrc_d [2];
  logic       alusrca_e [2], alusrc_e [2], pcsrc_e [2], jalr_e [2], memwrite_m [2];
  logic [3:0] aluctrl_e [2];
  logic [4:0] rs1_e [2], rs2_e [2], rd_e [2], rd_m [2], rd_w [2];
  logic [1:0] fwd_a_e [2], fwd_b_e [2], resultsrc_w [2];
  logic       regwrite_m [2], regwrite_w [2], illegal_d [2];
  logic       stall_f [2], stall_d [2], flush_d [2], flush_e [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_cu #(.LOAD_LATENCY(g == 0 ? LL0 : LL1), .ALUCTRL_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .instr_d(instr_d),
      .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .immsrc_d(immsrc_d[g]), .alusrca_e(alusrca_e[g]), .alusrc_e(alusrc_e[g]),
      .aluctrl_e(aluctrl_e[g]), .rs1_e(rs1_e[g]), .rs2_e(rs2_e[g]), .rd_e(rd_e[g]),
      .fwd_a_e(fwd_a_e[g]), .fwd_b_e(fwd_b_e[g]), .pcsrc_e(pcsrc_e[g]), .jalr_e(jalr_e[g]),
      .memwrite_m(memwrite_m[g]), .regwrite_m(regwrite_m[g]), .rd_m(rd_m[g]),
      .regwrite_w(regwrite_w[g]), .rd_w(rd_w[g]), .resultsrc_w(resultsrc_w[g]),
      .stall_f(stall_f[g]), .stall_d(stall_d[g]), .flush_d(flush_d[g]), .flush_e(flush_e[g]),
      .illegal_d(illegal_d[g])
    );
  end

  typedef struct packed {
    logic       rw, mw, br, jp, jr, asa, asb;
    logic [1:0] rsrc;
    logic [3:0] ac;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
  } bun_t;

  int unsigned checks = 0, errors = 0;
  bun_t        me [2], mm [2], mw [2];
  int unsigned owed [2];
  bit          trapped [2];
  bit          x_pc [2], x_st [2], x_haz [2], x_ill [2];

  function automatic bun_t ref_decode(input logic [31:0] ins);
    bun_t b;
    b = '0;
    b.f3 = ins[14:12]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20];
    case (ins[6:0])
      OP_R:     begin b.rw = 1; b.ac = {ins[30], ins[14:12]}; end
      OP_I:     begin b.rw = 1; b.asb = 1; b.ac = {(ins[14:12] == 3'b101) && ins[30], ins[14:12]}; end
      OP_LD:    begin b.rw = 1; b.asb = 1; b.rsrc = 2'd1; end
      OP_ST:    begin b.mw = 1; b.asb = 1; end
      OP_BR:    begin b.br = 1; b.ac = 4'b1000; end
      OP_JAL:   begin b.rw = 1; b.jp = 1; b.asa = 1; b.asb = 1; b.rsrc = 2'd2; end
      OP_JALR:  begin b.rw = 1; b.jp = 1; b.jr = 1; b.asb = 1; b.rsrc = 2'd2; end
      OP_LUI:   begin b.rw = 1; b.rsrc = 2'd3; end
      OP_AUIPC: begin b.rw = 1; b.asa = 1; b.asb = 1; end
      default:  ;
    endcase
    if (b.rw) b.rd = ins[11:7];
    return b;
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    if (op == OP_ST) return 3'd1;
    if (op == OP_BR) return 3'd2;
    if (op == OP_LUI || op == OP_AUIPC) return 3'd3;
    if (op == OP_JAL) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit ref_taken(input bun_t e, input logic z, input logic l, input logic lu);
    bit c;
    case (e.f3)
      3'b000: c = z;   3'b001: c = !z;
      3'b100: c = l;   3'b101: c = !l;
      3'b110: c = lu;  3'b111: c = !lu;
      default: c = 0;
    endcase
    return e.jp || (e.br && c);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input bun_t m, input bun_t w);
    if (m.rw && m.rd != 0 && m.rd == rs) return 2'b10;
    if (w.rw && w.rd != 0 && w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      me[k] = '0; mm[k] = '0; mw[k] = '0; owed[k] = 0; trapped[k] = 0;
    end
  endtask

  task automatic compare();
    logic [6:0] op;
    bit uses2, known;
    op = instr_d[6:0];
    uses2 = op inside {OP_R, OP_ST, OP_BR};
    known = op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int k = 0; k < 2; k++) begin
      x_haz[k] = (me[k].rsrc == 2'd1) && (me[k].rd != 0) &&
                 (me[k].rd == instr_d[19:15] || (uses2 && me[k].rd == instr_d[24:20]));
      x_pc[k]  = ref_taken(me[k], zero_e, lt_e, ltu_e) && !trapped[k];
      x_st[k]  = !x_pc[k] && (owed[k] != 0 || x_haz[k]);
      x_ill[k] = TRAP && !known && !x_pc[k];
      chk("immsrc_d", k, immsrc_d[k], ref_imm(op));
      chk("illegal_d", k, illegal_d[k], x_ill[k]);
      chk("alusrca_e", k, alusrca_e[k], me[k].asa);
      chk("alusrc_e", k, alusrc_e[k], me[k].asb);
      chk("aluctrl_e", k, aluctrl_e[k], me[k].ac);
      chk("rs1_e", k, rs1_e[k], me[k].rs1);
      chk("rs2_e", k, rs2_e[k], me[k].rs2);
      chk("rd_e", k, rd_e[k], me[k].rd);
      chk("jalr_e", k, jalr_e[k], me[k].jr);
      chk("fwd_a_e", k, fwd_a_e[k], ref_fwd(me[k].rs1, mm[k], mw[k]));
      chk("fwd_b_e", k, fwd_b_e[k], ref_fwd(me[k].rs2, mm[k], mw[k]));
      chk("pcsrc_e", k, pcsrc_e[k], x_pc[k]);
      chk("memwrite_m", k, memwrite_m[k], mm[k].mw);
      chk("regwrite_m", k, regwrite_m[k], mm[k].rw);
      chk("rd_m", k, rd_m[k], mm[k].rd);
      chk("regwrite_w", k, regwrite_w[k], mw[k].rw);
      chk("rd_w", k, rd_w[k], mw[k].rd);
      chk("resultsrc_w", k, resultsrc_w[k], mw[k].rsrc);
      chk("stall_f", k, stall_f[k], x_st[k]);
      chk("stall_d", k, stall_d[k], x_st[k]);
      chk("flush_d", k, flush_d[k], x_pc[k]);
      chk("flush_e", k, flush_e[k], x_pc[k] || x_st[k]);
    end
  endtask

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        mw[k] = mm[k];
        mm[k] = me[k];
        me[k] = (x_pc[k] || x_st[k]) ? bun_t'('0) : ref_decode(instr_d);
        if (x_pc[k]) owed[k] = 0;
        else if (owed[k] != 0) owed[k]--;
        else if (x_haz[k]) owed[k] = ((k == 0) ? LL0 : LL1) - 1;
        if (x_ill[k]) trapped[k] = 1;
      end
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic z, input logic l, input logic lu);
    instr_d = ins; zero_e = z; lt_e = l; ltu_e = lu;
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin drive(NOP, 0, 0, 0); tick(); end
  endtask

  function automatic logic [6:0] pick_op(input int unsigned n);
    case (n)
      0: return OP_R;   1: return OP_I;    2: return OP_LD;
      3: return OP_ST;  4: return OP_BR;   5: return OP_JAL;
      6: return OP_JALR; 7: return OP_LUI; default: return OP_AUIPC;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] add1, sub4, lw5, add7, beq, bne, jal5, ins;
    int unsigned n0, n1;
    add1 = {7'h00, 5'd3, 5'd2, 3'b000, 5'd1, OP_R};
    sub4 = {7'h20, 5'd5, 5'd1, 3'b000, 5'd4, OP_R};
    lw5  = {12'h000, 5'd6, 3'b010, 5'd5, OP_LD};
    add7 = {7'h00, 5'd5, 5'd5, 3'b000, 5'd7, OP_R};
    beq  = {7'h00, 5'd2, 5'd1, 3'b000, 5'd0, OP_BR};
    bne  = {7'h00, 5'd2, 5'd1, 3'b001, 5'd0, OP_BR};
    jal5 = {20'h00010, 5'd5, OP_JAL};
    ins  = NOP;

    model_reset();
    @(negedge clk);
    drive(NOP, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("reset_regwrite_w", k, regwrite_w[k], 0);
    tick();
    drive(NOP, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // NOP stream after reset release: writeback enable appears after three edges
    for (int i = 0; i < 5; i++) begin
      drive(NOP, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        chk("nop_regwrite_m", k, regwrite_m[k], i >= 2);
        chk("nop_regwrite_w", k, regwrite_w[k], i >= 3);
      end
      tick();
    end

    drive(add1, 0, 0, 0); tick();
    drive(sub4, 0, 0, 0); tick();
    drive(NOP, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("fwd_m_a", k, fwd_a_e[k], 2'b10);
    tick();
    drain(3);

    drive(add1, 0, 0, 0); tick();
    drive(NOP, 0, 0, 0); tick();
    drive(sub4, 0, 0, 0); tick();
    drive(NOP, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("fwd_w_a", k, fwd_a_e[k], 2'b01);
    tick();
    drain(3);

    drive(lw5, 0, 0, 0); tick();
    n0 = 0; n1 = 0;
    for (int i = 0; i < 5; i++) begin
      drive(add7, 0, 0, 0);
      n0 += stall_f[0];
      n1 += stall_f[1];
      if (i == 2) begin
        chk("lu_fwd_a", 0, fwd_a_e[0], 2'b01);
        chk("lu_fwd_b", 0, fwd_b_e[0], 2'b01);
      end
      tick();
    end
    chk("lu_stall_cycles", 0, n0, LL0);
    chk("lu_stall_cycles", 1, n1, LL1);
    drain(4);

    drive(beq, 0, 0, 0); tick();
    drive(NOP, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("beq_pcsrc", k, pcsrc_e[k], 1);
      chk("beq_flush_d", k, flush_d[k], 1);
      chk("beq_flush_e", k, flush_e[k], 1);
    end
    tick();
    drive(NOP, 1, 0, 0);
    for (int k = 0; k < 2; k++) chk("post_beq_pcsrc", k, pcsrc_e[k], 0);
    tick();
    drive(bne, 0, 0, 0); tick();
    drive(NOP, 1, 0, 0);
    for (int k = 0; k < 2; k++) chk("bne_pcsrc", k, pcsrc_e[k], 0);
    tick();
    drain(3);

    drive(jal5, 0, 0, 0); tick();
    drive(add7, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("jal_pcsrc", k, pcsrc_e[k], 1);
      chk("jal_stall_f", k, stall_f[k], 0);
    end
    tick();
    drain(3);

    // reset in the middle of the LOAD_LATENCY=3 stall
    drive(lw5, 0, 0, 0); tick();
    drive(add7, 0, 0, 0); tick();
    drive(add7, 0, 0, 0);
    chk("mid_stall_active", 1, stall_f[1], 1);
    rst_n = 1'b0;
    model_reset();
    drive(add7, 0, 0, 0);
    chk("rst_abandon_stall", 1, stall_f[1], 0);
    tick();
    rst_n = 1'b1;
    drive(add7, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("post_rst_stall", k, stall_f[k], 0);
    tick();
    drain(3);

    for (int i = 0; i < 400; i++) begin
      if (!(stall_f[0] || stall_f[1]) || $urandom_range(0, 3) == 0) begin
        ins = $urandom;
        ins[6:0]   = pick_op($urandom_range(0, 8));
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end
      drive(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    drain(4);

    drive(32'hFFFF_FFFF, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("illegal_const", k, illegal_d[k], TRAP);
    tick();
    drive(NOP, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("illegal_rd_e", k, rd_e[k], 0);
    tick();
    drive(NOP, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("illegal_regwrite_m", k, regwrite_m[k], 0);
    tick();
    drive(NOP, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("illegal_regwrite_w", k, regwrite_w[k], 0);
    tick();
    drive(jal5, 0, 0, 0); tick();
    drive(NOP, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("trap_freeze_pcsrc", k, pcsrc_e[k], !TRAP);
    tick();
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
